// File: rtl/gba_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : gba_gpu_pkg
// Brief  : Shared GPU drawer constants: VRAM geometry and requester indices.
// Rev    : 1.0
// ============================================================================
package gba_gpu_pkg;

    localparam int VRAM_AW    = 14;
    localparam int VRAM_DW    = 32;
    localparam int VRAM_RDLAT = 2;
    localparam int GPU_NREQ   = 4;

    // Requester slots on the VRAM drawer port; slot 0 may hold fixed priority
    localparam int REQ_OBJ = 0;
    localparam int REQ_BG0 = 1;
    localparam int REQ_BG1 = 2;
    localparam int REQ_BG2 = 3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gba_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : gba_rr_arbiter
// Brief  : Combinational round-robin picker with optional fixed top priority for index 0.
// Rev    : 1.0
// ============================================================================
module gba_rr_arbiter
    import gba_gpu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter bit PRIO0 = 1'b1,
    localparam int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_vld
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        if (PRIO0 && elig[REQ_OBJ]) begin
            grant[REQ_OBJ] = 1'b1;
            grant_idx      = PW'(REQ_OBJ);
            grant_vld      = 1'b1;
        end else begin
            // Cyclic scan starting at ptr; wrap explicitly so NREQ need not be 2^n
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NREQ)) begin
                    w_sum = w_sum - (PW+1)'(NREQ);
                end
                w_idx = w_sum[PW-1:0];
                if (!grant_vld && elig[w_idx]) begin
                    grant[w_idx] = 1'b1;
                    grant_idx    = w_idx;
                    grant_vld    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gba_vram_drawer_arbiter.sv
`default_nettype none
// ============================================================================
// Module : gba_vram_drawer_arbiter
// Brief  : Shares the pipelined VRAM drawer read port between NREQ drawers.
// Rev    : 1.0
// ============================================================================
module gba_vram_drawer_arbiter
    import gba_gpu_pkg::*;
#(
    parameter int NREQ  = GPU_NREQ,
    parameter int AW    = VRAM_AW,
    parameter int DW    = VRAM_DW,
    parameter int RDLAT = VRAM_RDLAT,
    parameter bit PRIO0 = 1'b1
) (
    input  logic             fclk,
    input  logic             resetn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]  rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_data,
    output logic             busy
);

    localparam int PW = idx_width(NREQ);
    localparam int TD = RDLAT + 1;

    logic [NREQ-1:0] r_outstanding;
    logic [PW-1:0]   r_ptr;
    logic [TD-1:0]   r_tag_vld;
    logic [PW-1:0]   r_tag_idx [TD];

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_gnt_idx;
    logic            w_gnt_vld;
    logic [NREQ-1:0] w_ret;

    // A requester in flight or in its return cycle cannot be granted again
    assign w_elig = req & ~r_outstanding & ~rd_valid;
    assign busy   = (|r_outstanding) | (|w_elig);

    gba_rr_arbiter #(
        .NREQ  (NREQ),
        .PRIO0 (PRIO0)
    ) u_rr (
        .elig      (w_elig),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gnt_idx),
        .grant_vld (w_gnt_vld)
    );

    always_comb begin
        w_ret = '0;
        if (r_tag_vld[RDLAT]) begin
            w_ret[r_tag_idx[RDLAT]] = 1'b1;
        end
    end

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_gnt_vld && !(PRIO0 && w_gnt_idx == PW'(REQ_OBJ))) begin
            r_ptr <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Return and grant never target the same requester, so clear and set commute
    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_ret) | (w_gnt_vld ? w_grant : '0);
        end
    end

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_rd <= w_gnt_vld;
            if (w_gnt_vld) begin
                mem_addr <= req_addr[int'(w_gnt_idx)*AW +: AW];
            end
        end
    end

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            r_tag_vld    <= '0;
            r_tag_idx[0] <= '0;
        end else begin
            r_tag_vld    <= {r_tag_vld[TD-2:0], w_gnt_vld};
            r_tag_idx[0] <= w_gnt_idx;
        end
    end

    for (genvar k = 1; k < TD; k++) begin : g_tag
        always_ff @(posedge fclk or negedge resetn) begin
            if (!resetn) begin
                r_tag_idx[k] <= '0;
            end else begin
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
        end
    end

    // Tag stage RDLAT lines up with mem_data for the read issued RDLAT+1 edges ago
    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= w_ret;
            if (r_tag_vld[RDLAT]) begin
                rd_data <= mem_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gba_vram_drawer_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_gba_vram_drawer_arbiter
// Brief  : Random and directed check of both arbitration modes against a cycle model.
// Rev    : 1.0
// ============================================================================
module tb_gba_vram_drawer_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int RDLAT = 2;

    logic                fclk = 1'b0;
    logic                resetn = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;

    logic [NREQ-1:0]     rd_valid [2];
    logic [DW-1:0]       rd_data  [2];
    logic                mem_rd   [2];
    logic [AW-1:0]       mem_addr [2];
    logic [DW-1:0]       mem_data [2];
    logic                busy     [2];

    logic [DW-1:0]       vram [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    // Model: per-requester remaining cycles to return (0 = idle)
    int                  cnt   [2][NREQ];
    logic [AW-1:0]       faddr [2][NREQ];
    int                  ptr   [2];
    logic [NREQ-1:0]     rdv   [2];
    logic [DW-1:0]       exp_data [2];

    always #5 fclk = ~fclk;

    for (genvar u = 0; u < 2; u++) begin : g_dut
        logic [AW-1:0] mq [RDLAT];

        gba_vram_drawer_arbiter #(
            .NREQ  (NREQ),
            .AW    (AW),
            .DW    (DW),
            .RDLAT (RDLAT),
            .PRIO0 (u == 1)
        ) dut (
            .fclk     (fclk),
            .resetn   (resetn),
            .req      (req),
            .req_addr (req_addr),
            .rd_valid (rd_valid[u]),
            .rd_data  (rd_data[u]),
            .mem_rd   (mem_rd[u]),
            .mem_addr (mem_addr[u]),
            .mem_data (mem_data[u]),
            .busy     (busy[u])
        );

        always @(posedge fclk) begin
            mq[0] <= mem_addr[u];
            for (int k = 1; k < RDLAT; k++) mq[k] <= mq[k-1];
        end
        assign mem_data[u] = vram[mq[RDLAT-1]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int u, input logic [NREQ-1:0] el);
        if (u == 1 && el[0]) return 0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr[u] + k) % NREQ;
            if (el[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < NREQ; i++) cnt[u][i] = 0;
            ptr[u] = 0;
            rdv[u] = '0;
            exp_data[u] = '0;
        end
    endtask

    task automatic step();
        int g [2];
        logic [NREQ-1:0] el;
        logic [NREQ-1:0] er;
        bit anyc;
        @(negedge fclk);
        for (int u = 0; u < 2; u++) begin
            el = '0;
            anyc = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && cnt[u][i] == 0 && !rdv[u][i]) el[i] = 1'b1;
                if (cnt[u][i] != 0) anyc = 1'b1;
            end
            g[u] = pick(u, el);
            check($sformatf("busy[%0d]", u), 64'(busy[u]), 64'(anyc || el != '0));
        end
        @(posedge fclk);
        #1;
        for (int u = 0; u < 2; u++) begin
            er = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (cnt[u][i] > 0) begin
                    cnt[u][i]--;
                    if (cnt[u][i] == 0) begin
                        er[i] = 1'b1;
                        exp_data[u] = vram[faddr[u][i]];
                    end
                end
            end
            if (g[u] >= 0) begin
                cnt[u][g[u]]   = RDLAT + 1;
                faddr[u][g[u]] = req_addr[g[u]*AW +: AW];
                if (!(u == 1 && g[u] == 0)) ptr[u] = (g[u] + 1) % NREQ;
            end
            rdv[u] = er;
            check($sformatf("rd_valid[%0d]", u), 64'(rd_valid[u]), 64'(er));
            check($sformatf("rd_data[%0d]", u), 64'(rd_data[u]), 64'(exp_data[u]));
            check($sformatf("mem_rd[%0d]", u), 64'(mem_rd[u]), 64'(g[u] >= 0));
            if (g[u] >= 0) begin
                check($sformatf("mem_addr[%0d]", u), 64'(mem_addr[u]), 64'(faddr[u][g[u]]));
            end
        end
    endtask

    task automatic do_reset();
        req = '0;
        #1;
        resetn = 1'b0;
        #1;
        model_clear();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst rd_valid[%0d]", u), 64'(rd_valid[u]), 64'(0));
            check($sformatf("rst rd_data[%0d]", u), 64'(rd_data[u]), 64'(0));
            check($sformatf("rst mem_rd[%0d]", u), 64'(mem_rd[u]), 64'(0));
            check($sformatf("rst mem_addr[%0d]", u), 64'(mem_addr[u]), 64'(0));
            check($sformatf("rst busy[%0d]", u), 64'(busy[u]), 64'(0));
        end
        repeat (2) @(posedge fclk);
        #3;
        resetn = 1'b1;
    endtask

    task automatic rand_addr();
        req_addr = (NREQ*AW)'({$urandom(), $urandom()});
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) vram[i] = $urandom();
        vram[14'h0123] = 32'hDEADBEEF;
        model_clear();

        do_reset();

        // Single read from requester 1
        rand_addr();
        req_addr[1*AW +: AW] = 14'h0123;
        req = 4'b0010;
        repeat (4) step();
        check("single rd_valid", 64'(rd_valid[0]), 64'(4'b0010));
        check("single rd_data", 64'(rd_data[0]), 64'(32'hDEADBEEF));
        req = '0;
        repeat (3) step();

        // All requesters held high
        req = 4'hF;
        repeat (24) begin rand_addr(); step(); end

        // Requester 0 always wanting service alongside requester 2
        req = 4'b0101;
        repeat (30) begin rand_addr(); step(); end
        req = '0;
        repeat (5) step();

        // Request held through its own return
        req = 4'b1000;
        repeat (15) begin rand_addr(); step(); end
        req = '0;
        repeat (5) step();

        // Request dropped right after grant
        req = 4'b0010;
        step();
        req = '0;
        repeat (8) begin rand_addr(); step(); end

        // Reset with reads in flight
        req = 4'hF;
        repeat (3) step();
        do_reset();
        repeat (2*RDLAT + 1) step();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom());
            rand_addr();
            step();
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
